// File: rtl/per2axi_req_sequencer_if.sv
// rtl/per2axi_req_sequencer_if.sv - peripheral slave port, AXI AW/W/AR channels, R/B monitor and accept strobe
// The master modport is the sequencer's view; the slave modport is the surrounding system's view.
interface per2axi_req_sequencer_if #(
   parameter int PER_ADDR_WIDTH = 32,
   parameter int PER_ID_WIDTH   = 5,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 6,
   parameter int AXI_ID_WIDTH   = 3
);
   logic                        per_slave_req;
   logic [PER_ADDR_WIDTH-1:0]   per_slave_add;
   logic                        per_slave_we;
   logic [31:0]                 per_slave_wdata;
   logic [3:0]                  per_slave_be;
   logic [PER_ID_WIDTH-1:0]     per_slave_id;
   logic                        per_slave_gnt;

   logic                        axi_master_aw_valid;
   logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr;
   logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id;
   logic [2:0]                  axi_master_aw_size;
   logic [7:0]                  axi_master_aw_len;
   logic [1:0]                  axi_master_aw_burst;
   logic [AXI_USER_WIDTH-1:0]   axi_master_aw_user;
   logic                        axi_master_aw_ready;

   logic                        axi_master_w_valid;
   logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data;
   logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb;
   logic                        axi_master_w_last;
   logic [AXI_USER_WIDTH-1:0]   axi_master_w_user;
   logic                        axi_master_w_ready;

   logic                        axi_master_ar_valid;
   logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr;
   logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id;
   logic [2:0]                  axi_master_ar_size;
   logic [7:0]                  axi_master_ar_len;
   logic [1:0]                  axi_master_ar_burst;
   logic [AXI_USER_WIDTH-1:0]   axi_master_ar_user;
   logic                        axi_master_ar_ready;

   logic                        axi_master_r_valid;
   logic                        axi_master_r_ready;
   logic                        axi_master_r_last;
   logic [AXI_ID_WIDTH-1:0]     axi_master_r_id;
   logic                        axi_master_b_valid;
   logic                        axi_master_b_ready;
   logic [AXI_ID_WIDTH-1:0]     axi_master_b_id;

   logic                        trans_req;
   logic [AXI_ID_WIDTH-1:0]     trans_id;
   logic [AXI_ADDR_WIDTH-1:0]   trans_add;

   modport master (
      input  per_slave_req, per_slave_add, per_slave_we, per_slave_wdata, per_slave_be, per_slave_id,
      output per_slave_gnt,
      output axi_master_aw_valid, axi_master_aw_addr, axi_master_aw_id, axi_master_aw_size,
             axi_master_aw_len, axi_master_aw_burst, axi_master_aw_user,
      input  axi_master_aw_ready,
      output axi_master_w_valid, axi_master_w_data, axi_master_w_strb, axi_master_w_last, axi_master_w_user,
      input  axi_master_w_ready,
      output axi_master_ar_valid, axi_master_ar_addr, axi_master_ar_id, axi_master_ar_size,
             axi_master_ar_len, axi_master_ar_burst, axi_master_ar_user,
      input  axi_master_ar_ready,
      input  axi_master_r_valid, axi_master_r_ready, axi_master_r_last, axi_master_r_id,
      input  axi_master_b_valid, axi_master_b_ready, axi_master_b_id,
      output trans_req, trans_id, trans_add
   );

   modport slave (
      output per_slave_req, per_slave_add, per_slave_we, per_slave_wdata, per_slave_be, per_slave_id,
      input  per_slave_gnt,
      input  axi_master_aw_valid, axi_master_aw_addr, axi_master_aw_id, axi_master_aw_size,
             axi_master_aw_len, axi_master_aw_burst, axi_master_aw_user,
      output axi_master_aw_ready,
      input  axi_master_w_valid, axi_master_w_data, axi_master_w_strb, axi_master_w_last, axi_master_w_user,
      output axi_master_w_ready,
      input  axi_master_ar_valid, axi_master_ar_addr, axi_master_ar_id, axi_master_ar_size,
             axi_master_ar_len, axi_master_ar_burst, axi_master_ar_user,
      output axi_master_ar_ready,
      output axi_master_r_valid, axi_master_r_ready, axi_master_r_last, axi_master_r_id,
      output axi_master_b_valid, axi_master_b_ready, axi_master_b_id,
      input  trans_req, trans_id, trans_add
   );
endinterface

// File: rtl/per2axi_req_sequencer.sv
// rtl/per2axi_req_sequencer.sv - single-beat peripheral request to AXI4 AR or AW+W sequencer
// Define PER2AXI_OUTSTANDING_TRACK_EN to hold off a core until its previous response has been handed off.
module per2axi_req_sequencer #(
   parameter int NB_CORES       = 4,
   parameter int PER_ADDR_WIDTH = 32,
   parameter int PER_ID_WIDTH   = 5,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 6,
   parameter int AXI_ID_WIDTH   = 3
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   per2axi_req_sequencer_if.master        bus
);
   localparam int NB_IDS = 1 << AXI_ID_WIDTH;

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t                    state_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic [31:0]               wdata_q;
   logic [3:0]                be_q;
   logic                      aw_pend_q;
   logic                      w_pend_q;
   logic                      ar_valid_q;

   logic [AXI_ID_WIDTH-1:0]   id_bin;
   logic                      blocked;
   logic                      gnt;
   logic [63:0]               unused_cfg;

   assign unused_cfg = {32'(NB_CORES), 32'(PER_ADDR_WIDTH)};

   // Lowest set bit wins; an all-zero ID falls through to 0.
   always_comb begin
      id_bin = '0;
      for (int i = PER_ID_WIDTH - 1; i >= 0; i--) begin
         if (bus.per_slave_id[i]) id_bin = AXI_ID_WIDTH'(i);
      end
   end

   assign gnt = (state_q == IDLE) && bus.per_slave_req && !blocked;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         id_q       <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         aw_pend_q  <= 1'b0;
         w_pend_q   <= 1'b0;
         ar_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt) begin
                  addr_q  <= bus.per_slave_add[AXI_ADDR_WIDTH-1:0];
                  id_q    <= id_bin;
                  wdata_q <= bus.per_slave_wdata;
                  be_q    <= bus.per_slave_be;
                  if (bus.per_slave_we) begin
                     ar_valid_q <= 1'b1;
                     state_q    <= READ;
                  end else begin
                     aw_pend_q <= 1'b1;
                     w_pend_q  <= 1'b1;
                     state_q   <= WRITE;
                  end
               end
            end
            WRITE: begin
               // AW and W retire independently; leave once neither is pending after this edge.
               if (bus.axi_master_aw_ready) aw_pend_q <= 1'b0;
               if (bus.axi_master_w_ready)  w_pend_q  <= 1'b0;
               if ((!aw_pend_q || bus.axi_master_aw_ready) && (!w_pend_q || bus.axi_master_w_ready))
                  state_q <= IDLE;
            end
            READ: begin
               if (bus.axi_master_ar_ready) begin
                  ar_valid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef PER2AXI_OUTSTANDING_TRACK_EN
   logic [NB_IDS-1:0] outstanding_q;
   logic [NB_IDS-1:0] outstanding_d;

   assign blocked = outstanding_q[id_bin];

   always_comb begin
      outstanding_d = outstanding_q;
      if (bus.axi_master_r_valid && bus.axi_master_r_ready && bus.axi_master_r_last)
         outstanding_d[bus.axi_master_r_id] = 1'b0;
      if (bus.axi_master_b_valid && bus.axi_master_b_ready)
         outstanding_d[bus.axi_master_b_id] = 1'b0;
      if (gnt)
         outstanding_d[id_bin] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) outstanding_q <= '0;
      else         outstanding_q <= outstanding_d;
   end
`else
   logic unused_mon;

   assign blocked    = 1'b0;
   assign unused_mon = ^{bus.axi_master_r_valid, bus.axi_master_r_ready, bus.axi_master_r_last,
                         bus.axi_master_r_id, bus.axi_master_b_valid, bus.axi_master_b_ready,
                         bus.axi_master_b_id};
`endif

   assign bus.per_slave_gnt       = gnt;

   assign bus.axi_master_aw_valid = aw_pend_q;
   assign bus.axi_master_aw_addr  = addr_q;
   assign bus.axi_master_aw_id    = id_q;
   assign bus.axi_master_aw_size  = 3'b010;
   assign bus.axi_master_aw_len   = 8'd0;
   assign bus.axi_master_aw_burst = 2'b01;
   assign bus.axi_master_aw_user  = '0;

   // 32-bit word lands in the 64-bit lane selected by address bit 2.
   assign bus.axi_master_w_valid  = w_pend_q;
   assign bus.axi_master_w_data   = addr_q[2] ? {wdata_q, 32'h0} : {32'h0, wdata_q};
   assign bus.axi_master_w_strb   = addr_q[2] ? {be_q, 4'h0} : {4'h0, be_q};
   assign bus.axi_master_w_last   = 1'b1;
   assign bus.axi_master_w_user   = '0;

   assign bus.axi_master_ar_valid = ar_valid_q;
   assign bus.axi_master_ar_addr  = addr_q;
   assign bus.axi_master_ar_id    = id_q;
   assign bus.axi_master_ar_size  = 3'b010;
   assign bus.axi_master_ar_len   = 8'd0;
   assign bus.axi_master_ar_burst = 2'b01;
   assign bus.axi_master_ar_user  = '0;

   assign bus.trans_req = gnt;
   assign bus.trans_id  = id_bin;
   assign bus.trans_add = bus.per_slave_add[AXI_ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_per2axi_req_sequencer.sv
// tb/tb_per2axi_req_sequencer.sv - self-checking bench for per2axi_req_sequencer
// Transaction-level model plus directed literal checks; honours PER2AXI_OUTSTANDING_TRACK_EN.
module tb_per2axi_req_sequencer;
`ifdef PER2AXI_OUTSTANDING_TRACK_EN
   localparam bit TRACK = 1'b1;
`else
   localparam bit TRACK = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   per2axi_req_sequencer_if bus ();

   per2axi_req_sequencer dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] first_one(input logic [4:0] v);
      for (int i = 0; i < 5; i++) if (v[i]) return 3'(i);
      return 3'd0;
   endfunction

   // Model: which AXI channels still owe a handshake, the captured request, and busy cores.
   logic        m_ar, m_aw, m_w;
   logic [31:0] m_addr, m_wdata;
   logic [2:0]  m_id;
   logic [3:0]  m_be;
   logic [7:0]  m_out;

   always @(negedge clk) begin : compare
      logic        exp_gnt;
      logic [63:0] exp_data;
      logic [7:0]  exp_strb;
      logic [2:0]  rid;
      if (!rst_n) begin
         m_ar = 0; m_aw = 0; m_w = 0; m_out = '0;
         m_addr = 0; m_wdata = 0; m_id = 0; m_be = 0;
         chk("rst_aw_valid", bus.axi_master_aw_valid, 0);
         chk("rst_w_valid", bus.axi_master_w_valid, 0);
         chk("rst_ar_valid", bus.axi_master_ar_valid, 0);
         chk("rst_gnt", bus.per_slave_gnt, 0);
         chk("rst_trans_req", bus.trans_req, 0);
         chk("rst_ar_addr", bus.axi_master_ar_addr, 0);
         chk("rst_w_data", bus.axi_master_w_data, 0);
         chk("rst_w_strb", bus.axi_master_w_strb, 0);
      end else begin
         rid = first_one(bus.per_slave_id);
         exp_gnt = bus.per_slave_req && !(m_ar || m_aw || m_w) && !(TRACK && m_out[rid]);
         chk("gnt", bus.per_slave_gnt, exp_gnt);
         chk("trans_req", bus.trans_req, exp_gnt);
         chk("trans_id", bus.trans_id, rid);
         chk("trans_add", bus.trans_add, bus.per_slave_add);
         chk("aw_valid", bus.axi_master_aw_valid, m_aw);
         chk("w_valid", bus.axi_master_w_valid, m_w);
         chk("ar_valid", bus.axi_master_ar_valid, m_ar);
         if (m_aw) begin
            chk("aw_addr", bus.axi_master_aw_addr, m_addr);
            chk("aw_id", bus.axi_master_aw_id, m_id);
         end
         if (m_w) begin
            exp_data = m_addr[2] ? {m_wdata, 32'h0} : {32'h0, m_wdata};
            exp_strb = m_addr[2] ? {m_be, 4'h0} : {4'h0, m_be};
            chk("w_data", bus.axi_master_w_data, exp_data);
            chk("w_strb", bus.axi_master_w_strb, exp_strb);
         end
         if (m_ar) begin
            chk("ar_addr", bus.axi_master_ar_addr, m_addr);
            chk("ar_id", bus.axi_master_ar_id, m_id);
         end
         chk("fixed_fields", {bus.axi_master_aw_size, bus.axi_master_aw_len, bus.axi_master_aw_burst,
                              bus.axi_master_ar_size, bus.axi_master_ar_len, bus.axi_master_ar_burst,
                              bus.axi_master_w_last, bus.axi_master_aw_user, bus.axi_master_ar_user,
                              bus.axi_master_w_user},
             {3'd2, 8'd0, 2'd1, 3'd2, 8'd0, 2'd1, 1'b1, 18'd0});
         if (m_ar && bus.axi_master_ar_ready) m_ar = 0;
         if (m_aw && bus.axi_master_aw_ready) m_aw = 0;
         if (m_w && bus.axi_master_w_ready) m_w = 0;
         if (bus.axi_master_r_valid && bus.axi_master_r_ready && bus.axi_master_r_last)
            m_out[bus.axi_master_r_id] = 0;
         if (bus.axi_master_b_valid && bus.axi_master_b_ready)
            m_out[bus.axi_master_b_id] = 0;
         if (exp_gnt) begin
            m_addr = bus.per_slave_add; m_id = rid;
            m_wdata = bus.per_slave_wdata; m_be = bus.per_slave_be;
            if (bus.per_slave_we) m_ar = 1;
            else begin m_aw = 1; m_w = 1; end
            m_out[rid] = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk); #1;
   endtask

   task automatic set_req(input logic we, input logic [31:0] add, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [4:0] id);
      bus.per_slave_req = 1; bus.per_slave_we = we; bus.per_slave_add = add;
      bus.per_slave_wdata = wdata; bus.per_slave_be = be; bus.per_slave_id = id;
   endtask

   task automatic resp_rb(input logic r_en, input logic [2:0] r_id, input logic b_en, input logic [2:0] b_id);
      bus.axi_master_r_valid = r_en; bus.axi_master_r_ready = r_en; bus.axi_master_r_last = r_en;
      bus.axi_master_r_id = r_id;
      bus.axi_master_b_valid = b_en; bus.axi_master_b_ready = b_en; bus.axi_master_b_id = b_id;
      step();
      bus.axi_master_r_valid = 0; bus.axi_master_r_ready = 0; bus.axi_master_r_last = 0;
      bus.axi_master_b_valid = 0; bus.axi_master_b_ready = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0;
      rst_n = 0;
      bus.per_slave_req = 0; bus.per_slave_add = 0; bus.per_slave_we = 0;
      bus.per_slave_wdata = 0; bus.per_slave_be = 0; bus.per_slave_id = 0;
      bus.axi_master_aw_ready = 0; bus.axi_master_w_ready = 0; bus.axi_master_ar_ready = 0;
      bus.axi_master_r_valid = 0; bus.axi_master_r_ready = 0; bus.axi_master_r_last = 0;
      bus.axi_master_r_id = 0; bus.axi_master_b_valid = 0; bus.axi_master_b_ready = 0;
      bus.axi_master_b_id = 0;
      mid();
      chk("lit_reset_ar_valid", bus.axi_master_ar_valid, 0);
      chk("lit_reset_w_last", bus.axi_master_w_last, 1);
      repeat (2) step();
      rst_n = 1;

      // Read: grant and strobe in cycle 0, AR in cycle 1
      bus.axi_master_ar_ready = 1;
      set_req(1, 32'h1000_0004, 0, 4'hF, 5'b00100);
      mid();
      chk("lit_rd_gnt", bus.per_slave_gnt, 1);
      chk("lit_rd_trans_req", bus.trans_req, 1);
      chk("lit_rd_trans_id", bus.trans_id, 2);
      chk("lit_rd_trans_add", bus.trans_add, 32'h1000_0004);
      step(); bus.per_slave_req = 0;
      mid();
      chk("lit_rd_ar_valid", bus.axi_master_ar_valid, 1);
      chk("lit_rd_ar_addr", bus.axi_master_ar_addr, 32'h1000_0004);
      chk("lit_rd_ar_id", bus.axi_master_ar_id, 2);
      chk("lit_rd_ar_size", bus.axi_master_ar_size, 2);
      chk("lit_rd_ar_len", bus.axi_master_ar_len, 0);
      step();
      resp_rb(1, 3'd2, 0, 3'd0);

      // Write to upper lane
      bus.axi_master_aw_ready = 1; bus.axi_master_w_ready = 1;
      set_req(0, 32'h0000_0004, 32'hDEADBEEF, 4'b0011, 5'b00001);
      mid();
      chk("lit_wr_gnt", bus.per_slave_gnt, 1);
      step(); bus.per_slave_req = 0;
      mid();
      chk("lit_wr_w_valid", bus.axi_master_w_valid, 1);
      chk("lit_wr_w_data", bus.axi_master_w_data, 64'hDEADBEEF_00000000);
      chk("lit_wr_w_strb", bus.axi_master_w_strb, 8'b0011_0000);
      chk("lit_wr_w_last", bus.axi_master_w_last, 1);
      step();
      resp_rb(0, 3'd0, 1, 3'd0);

      // Write, lower lane, AW stalled three cycles
      bus.axi_master_aw_ready = 0; bus.axi_master_w_ready = 1;
      set_req(0, 32'h0000_0020, 32'h12345678, 4'hF, 5'b00010);
      mid(); chk("lit_st_gnt", bus.per_slave_gnt, 1);
      step(); bus.per_slave_req = 0;
      mid();
      chk("lit_st_c1_w_valid", bus.axi_master_w_valid, 1);
      chk("lit_st_c1_w_data", bus.axi_master_w_data, 64'h0000_0000_1234_5678);
      chk("lit_st_c1_w_strb", bus.axi_master_w_strb, 8'h0F);
      step();
      mid(); chk("lit_st_c2_w_valid", bus.axi_master_w_valid, 0); chk("lit_st_c2_aw_valid", bus.axi_master_aw_valid, 1);
      step();
      mid(); chk("lit_st_c3_w_valid", bus.axi_master_w_valid, 0);
      step();
      bus.axi_master_aw_ready = 1;
      set_req(1, 32'h0000_0040, 0, 4'hF, 5'b01000);
      mid(); chk("lit_st_c4_aw_valid", bus.axi_master_aw_valid, 1); chk("lit_st_c4_gnt", bus.per_slave_gnt, 0);
      step();
      mid(); chk("lit_st_c5_aw_valid", bus.axi_master_aw_valid, 0); chk("lit_st_c5_gnt", bus.per_slave_gnt, 1);
      step(); bus.per_slave_req = 0;
      step();
      resp_rb(1, 3'd3, 1, 3'd1);

      // Same-core back-to-back reads
      set_req(1, 32'h0000_0100, 0, 4'hF, 5'b00001);
      mid(); chk("lit_bk_c0_gnt", bus.per_slave_gnt, 1);
      step();
      mid(); chk("lit_bk_c1_gnt", bus.per_slave_gnt, 0);
      step();
      mid(); chk("lit_bk_c2_gnt", bus.per_slave_gnt, TRACK ? 1'b0 : 1'b1);
      step();
      if (TRACK) begin
         set_req(1, 32'h0000_0104, 0, 4'hF, 5'b00010);
         mid(); chk("lit_bk_c3_other_gnt", bus.per_slave_gnt, 1);
         step();
         set_req(1, 32'h0000_0100, 0, 4'hF, 5'b00001);
         resp_rb(1, 3'd0, 0, 3'd0);
         mid(); chk("lit_bk_c5_gnt", bus.per_slave_gnt, 1);
         step();
      end
      bus.per_slave_req = 0;
      step(); step();
      resp_rb(1, 3'd0, 0, 3'd0);
      resp_rb(1, 3'd1, 0, 3'd0);

      // Reset while AW and W are both pending
      bus.axi_master_aw_ready = 0; bus.axi_master_w_ready = 0;
      set_req(0, 32'h0000_0008, 32'hA5A5A5A5, 4'hF, 5'b00100);
      mid(); chk("lit_rs_gnt", bus.per_slave_gnt, 1);
      step(); bus.per_slave_req = 0;
      mid(); chk("lit_rs_aw_valid", bus.axi_master_aw_valid, 1);
      #2; rst_n = 0; #1;
      chk("lit_rs_async_aw_valid", bus.axi_master_aw_valid, 0);
      chk("lit_rs_async_w_valid", bus.axi_master_w_valid, 0);
      chk("lit_rs_async_ar_valid", bus.axi_master_ar_valid, 0);
      step(); step();
      rst_n = 1;
      bus.axi_master_ar_ready = 1;
      set_req(1, 32'h0000_0200, 0, 4'hF, 5'b00100);
      mid(); chk("lit_rs_post_gnt", bus.per_slave_gnt, 1);
      step(); bus.per_slave_req = 0;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/per2axi_req_sequencer.md
# per2axi_req_sequencer

Upstream neighbour of the per2axi response channel. Accepts single-beat 32-bit peripheral-interconnect requests and turns them into AXI4 single-beat transactions: AR for reads; AW and W for writes, with independent handshakes. On every accepted request it emits the `trans_req/trans_id/trans_add` strobe that the response channel uses for read-lane selection. Optionally blocks a new request from a core that still has a transaction outstanding.

## Interface

**Parameters**
- `NB_CORES`, 4: number of cores (one-hot peripheral ID bits).
- `PER_ADDR_WIDTH`, 32: peripheral address width.
- `PER_ID_WIDTH`, 5: one-hot peripheral ID width.
- `AXI_ADDR_WIDTH`, 32: AXI address width. Must be ≤ `PER_ADDR_WIDTH`.
- `AXI_DATA_WIDTH`, 64: AXI data width. Fixed at 64.
- `AXI_USER_WIDTH`, 6: AXI user width.
- `AXI_ID_WIDTH`, 3: AXI ID width. Must satisfy 2^`AXI_ID_WIDTH` ≥ `PER_ID_WIDTH`.

**Ports**
- `clk_i` in 1: clock. One clock domain.
- `rst_ni` in 1: asynchronous active-low reset.
- `per_slave_req_i` in 1: request valid.
- `per_slave_add_i` in `PER_ADDR_WIDTH`: byte address.
- `per_slave_we_i` in 1: 1 = read, 0 = write.
- `per_slave_wdata_i` in 32: write data.
- `per_slave_be_i` in 4: byte enables.
- `per_slave_id_i` in `PER_ID_WIDTH`: one-hot requester ID.
- `per_slave_gnt_o` out 1: request accepted this cycle.
- `axi_master_aw_valid_o`, `_aw_addr_o`, `_aw_id_o`, `_aw_size_o`, `_aw_len_o`, `_aw_burst_o`, `_aw_user_o` out; `axi_master_aw_ready_i` in.
- `axi_master_w_valid_o`, `_w_data_o`[64], `_w_strb_o`[8], `_w_last_o`, `_w_user_o` out; `axi_master_w_ready_i` in.
- `axi_master_ar_*` out (same fields as AW); `axi_master_ar_ready_i` in.
- `axi_master_r_valid_i`, `axi_master_r_ready_i`, `axi_master_r_last_i`, `axi_master_r_id_i` in: R handshake monitor (tracking).
- `axi_master_b_valid_i`, `axi_master_b_ready_i`, `axi_master_b_id_i` in: B handshake monitor (tracking).
- `trans_req_o` out 1, `trans_id_o` out `AXI_ID_WIDTH`, `trans_add_o` out `AXI_ADDR_WIDTH`: accept strobe to the response channel.

## Operation

**ID encoding**
- `id_bin` = index of the lowest set bit of `per_slave_id_i`.
- All-zero ID encodes as 0.

**States:** IDLE, WRITE, READ.

**IDLE**
- `per_slave_gnt_o = per_slave_req_i & ~blocked`.
- `blocked = outstanding[id_bin]` when tracking is compiled in; otherwise `blocked = 0`.
- On grant, register address, `id_bin`, data and byte enables.
- Read grant: go to READ.
- Write grant: go to WRITE with `aw_pend = 1` and `w_pend = 1`.

**WRITE**
- `aw_valid = aw_pend`; `w_valid = w_pend`.
- Each pend flag clears on its own valid&ready handshake.
- AW and W may complete in either order or in the same cycle.
- Go to IDLE in the cycle after both flags are clear.

**READ**
- `ar_valid = 1` until `ar_ready`, then go to IDLE.

**Fixed AXI fields**
- size = 3'b010, len = 0, burst = 2'b01 (INCR), user = 0, `w_last = 1`.
- addr = registered address truncated to `AXI_ADDR_WIDTH`.

**Write lane placement (by address bit 2)**
- add[2] = 0: `w_data = {32'h0, wdata}`, `w_strb = {4'h0, be}`.
- add[2] = 1: `w_data = {wdata, 32'h0}`, `w_strb = {be, 4'h0}`.

**Accept strobe**
- `trans_req_o = per_slave_gnt_o` (combinational).
- `trans_id_o = id_bin`; `trans_add_o = per_slave_add_i[AXI_ADDR_WIDTH-1:0]`.

**Outstanding tracking**
- Bit `id_bin` sets on grant.
- Cleared by `r_valid & r_ready & r_last` on `r_id`, or by `b_valid & b_ready` on `b_id`.
- R and B clears on different IDs in the same cycle both apply.

## Timing

**Reset values**
- All outputs 0, except the constant fields (size, len, burst, `w_last`), which always hold their fixed values.
- State = IDLE; all outstanding bits and pend flags = 0.

**Latency**
- Grant is combinational in cycle 0.
- AW/W/AR valid rises in cycle 1.
- Minimum issue interval: read = 2 cycles (ar_ready held high); write = 2 cycles (aw_ready and w_ready held high).

**Handshake rules**
- Valid outputs and their payloads are held stable until ready; no valid is withdrawn.
- No grant in WRITE or READ.

**Reset mid-transaction**
- Valids drop asynchronously and the transaction is lost.
- The AXI slave is reset together with this block.

**Illegal use**
- A response for an ID that is not outstanding leaves the bit 0.

## Configuration

- `PER2AXI_OUTSTANDING_TRACK_EN` defined: per-ID outstanding register present. A core is not granted until its previous response has been handed off.
- Not defined: no tracking register; `blocked = 0`. The R/B monitor inputs are unused.

## Test plan

- Read, add=0x1000_0004, id=5'b00100 → gnt cycle 0 with `trans_req_o = 1`, `trans_id_o = 2`, `trans_add_o = 0x1000_0004`. Cycle 1: `ar_valid = 1`, ar_addr = 0x1000_0004, ar_id = 2, size = 2, len = 0.
- Write add=0x0000_0004, wdata=0xDEADBEEF, be=4'b0011 → `w_data = 0xDEADBEEF_00000000`, `w_strb = 8'b0011_0000`, `w_last = 1`.
- Write with aw_ready held low for 3 cycles and w_ready high → W completes in cycle 1, AW in cycle 4, IDLE in cycle 5. `w_valid` is never reasserted.
- Tracking on: read id 0, then a second request from id 0 before R → gnt = 0. After R with last (id 0) → gnt the following cycle. A request from id 1 meanwhile → granted.
- Tracking off: same sequence → second request granted as soon as the FSM returns to IDLE.
- Reset asserted while in WRITE with aw_pend = 1 → all valids 0 immediately. After release: IDLE, gnt follows req.
